matmul_seq_ctrl: RTL

Sequencer for the matrix-multiply datapath. It is started by the APB register block with latched dimensions and scratchpad-target selects. It then:
- clears the PE accumulator array;
- streams K operand-read steps (outer-product accumulation);
- requests scratchpad ownership;
- writes N result rows, optionally adding a bias row read back from a source target.

It holds no data, only control.

---
 rtl/matmul_pkg.sv | 19 +
 rtl/matmul_delay_line.sv | 31 +++
 rtl/matmul_seq_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared dimensions, types and state encoding for the matmul sequencer.
package matmul_pkg;
  localparam int MAX_DIM = 4;
  localparam int SP_NTARGETS = 4;
  localparam int DIM_W = $clog2(MAX_DIM);
  localparam int TGT_W = $clog2(SP_NTARGETS);
  typedef logic [DIM_W-1:0] dim_t;
  typedef logic [TGT_W-1:0] tgt_t;
  typedef logic [MAX_DIM-1:0] elements_data_bus_t;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_ACCUM, ST_DRAIN, ST_SP_REQ, ST_WRITE, ST_DONE
  } state_t;
  function automatic elements_data_bus_t col_mask_f(input dim_t m);
    elements_data_bus_t mask;
    mask = '0;
    for (int i = 0; i < MAX_DIM; i++) mask[i] = (i <= int'(m));
    return mask;
  endfunction
endpackage

// File: rtl/matmul_delay_line.sv
// matmul_delay_line: fixed-depth valid+payload shift register with synchronous flush.
module matmul_delay_line #(
  parameter int DEPTH = 1,
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_v_i,
  input  logic [W-1:0] in_d_i,
  output logic         out_v_o,
  output logic [W-1:0] out_d_o
);
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0][W-1:0] r_d;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_v <= '0;
      r_d <= '0;
    end else begin
      r_v[0] <= in_v_i;
      r_d[0] <= in_d_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_v[i] <= r_v[i-1];
        r_d[i] <= r_d[i-1];
      end
    end
  end
  assign out_v_o = r_v[DEPTH-1];
  assign out_d_o = r_d[DEPTH-1];
endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: clear / accumulate / drain / scratchpad-request / write-back sequencer.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int OP_RD_LAT = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  dim_t               n_dim_i,
  input  dim_t               k_dim_i,
  input  dim_t               m_dim_i,
  input  logic               bias_en_i,
  input  tgt_t               src_tgt_i,
  input  tgt_t               dst_tgt_i,
  input  logic               sp_gnt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               start_err_o,
  output logic               pe_clear_o,
  output logic               op_rd_en_o,
  output dim_t               op_rd_k_o,
  output logic               pe_acc_en_o,
  output elements_data_bus_t col_mask_o,
  output logic               sp_req_o,
  output logic               sp_rd_en_o,
  output dim_t               sp_rd_row_o,
  output tgt_t               sp_rd_tgt_o,
  output logic               sp_wr_en_o,
  output dim_t               sp_wr_row_o,
  output tgt_t               sp_wr_tgt_o
);
  state_t r_state;
  dim_t r_n_dim, r_k_dim, r_op_rd_k, r_sp_rd_row;
  tgt_t r_src_tgt, r_dst_tgt;
  elements_data_bus_t r_col_mask;
  logic r_bias_en, r_busy, r_done, r_start_err, r_pe_clear, r_op_rd_en, r_sp_req, r_sp_rd_en, r_wr_stage;
  logic w_flush, w_acc_v;
  dim_t w_acc_k;
  assign w_flush = abort_i && r_state != ST_IDLE;
  // The delayed k index tells DRAIN when the final operand has been accumulated.
  matmul_delay_line #(.DEPTH(OP_RD_LAT), .W(DIM_W)) u_acc_dl (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(w_flush), .in_v_i(r_op_rd_en), .in_d_i(r_op_rd_k),
    .out_v_o(w_acc_v), .out_d_o(w_acc_k)
  );
  matmul_delay_line #(.DEPTH(1), .W(DIM_W)) u_wr_dl (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(w_flush), .in_v_i(r_wr_stage), .in_d_i(r_sp_rd_row),
    .out_v_o(sp_wr_en_o), .out_d_o(sp_wr_row_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      {r_n_dim, r_k_dim, r_op_rd_k, r_sp_rd_row} <= '0;
      {r_src_tgt, r_dst_tgt, r_col_mask} <= '0;
      {r_bias_en, r_busy, r_done, r_start_err, r_pe_clear} <= '0;
      {r_op_rd_en, r_sp_req, r_sp_rd_en, r_wr_stage} <= '0;
    end else if (w_flush) begin
      r_state <= ST_IDLE;
      {r_op_rd_k, r_sp_rd_row} <= '0;
      {r_busy, r_done, r_start_err, r_pe_clear} <= '0;
      {r_op_rd_en, r_sp_req, r_sp_rd_en, r_wr_stage} <= '0;
    end else begin
      r_start_err <= start_i && r_state != ST_IDLE;
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_state <= ST_CLEAR;
          r_n_dim <= n_dim_i;
          r_k_dim <= k_dim_i;
          r_bias_en <= bias_en_i;
          r_src_tgt <= src_tgt_i;
          r_dst_tgt <= dst_tgt_i;
          r_col_mask <= col_mask_f(m_dim_i);
          r_busy <= 1'b1;
          r_pe_clear <= 1'b1;
        end
        ST_CLEAR: begin
          r_state <= ST_ACCUM;
          r_pe_clear <= 1'b0;
          r_op_rd_en <= 1'b1;
          r_op_rd_k <= '0;
        end
        ST_ACCUM: if (r_op_rd_k == r_k_dim) begin
          r_state <= ST_DRAIN;
          r_op_rd_en <= 1'b0;
        end else r_op_rd_k <= r_op_rd_k + 1'b1;
        ST_DRAIN: if (w_acc_v && w_acc_k == r_k_dim) begin
          r_state <= ST_SP_REQ;
          r_sp_req <= 1'b1;
        end
        ST_SP_REQ: if (sp_gnt_i) begin
          r_state <= ST_WRITE;
          r_sp_rd_en <= r_bias_en;
          r_sp_rd_row <= '0;
          r_wr_stage <= 1'b1;
        end
        ST_WRITE: if (r_sp_rd_row == r_n_dim) begin
          r_state <= ST_DONE;
          r_sp_rd_en <= 1'b0;
          r_wr_stage <= 1'b0;
          r_done <= 1'b1;
        end else r_sp_rd_row <= r_sp_rd_row + 1'b1;
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done <= 1'b0;
          r_sp_req <= 1'b0;
          r_busy <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign start_err_o = r_start_err;
  assign pe_clear_o = r_pe_clear;
  assign op_rd_en_o = r_op_rd_en;
  assign op_rd_k_o = r_op_rd_k;
  assign pe_acc_en_o = w_acc_v;
  assign col_mask_o = r_col_mask;
  assign sp_req_o = r_sp_req;
  assign sp_rd_en_o = r_sp_rd_en;
  assign sp_rd_row_o = r_sp_rd_row;
  assign sp_rd_tgt_o = r_src_tgt;
  assign sp_wr_tgt_o = r_dst_tgt;
endmodule
